// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: clk-domain sampler for a ripple counter; cnt_in (async) -> filtered cnt_out/valid with upd/match/wrap pulses and saturating wrap_cnt
module ripple_count_sampler #(
  parameter int WIDTH     = 4,
  parameter int MODE_DOWN = 1,
  parameter int STABLE    = 2,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  match_val,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              valid,
  output logic              upd,
  output logic              match,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);
  localparam logic [2:0] STB    = 3'(STABLE);
  localparam logic [2:0] STB_M1 = 3'(STABLE - 1);
  logic [WIDTH-1:0] s1, s2, s3;
  logic [2:0]       run_len;
  logic             same, acc, wrap_now;
  assign same     = s2 == s3;
  assign acc      = en && !clr && same && run_len >= STB_M1 && (!valid || s2 != cnt_out);
  assign wrap_now = valid && ((MODE_DOWN != 0) ? (s2 > cnt_out) : (s2 < cnt_out));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      run_len  <= '0;
      cnt_out  <= '0;
      valid    <= 1'b0;
      upd      <= 1'b0;
      match    <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      s3      <= s2;
      run_len <= !same ? 3'd0 : (run_len < STB) ? run_len + 3'd1 : STB;
      upd     <= acc;
      match   <= acc && s2 == match_val;
      wrap    <= acc && wrap_now;
      if (clr) begin
        valid    <= 1'b0;
        wrap_cnt <= '0;
      end else if (acc) begin
        cnt_out <= s2;
        valid   <= 1'b1;
        if (wrap_now && wrap_cnt != '1) wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: table-driven plus hand sequences for ripple_count_sampler
module tb_ripple_count_sampler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cnt_in, match_val, cnt_out;
  logic       en, clr, valid, upd, match, wrap;
  logic [7:0] wrap_cnt;
  logic [3:0] cnt1, cnt_out1;
  logic       valid1, upd1, match1, wrap1;
  logic [7:0] wrap_cnt1;
  int errs = 0, checks = 0;
  int n_upd = 0, n_match = 0, n_wrap = 0, n_upd1 = 0, n_wrap1 = 0;
  always #5 clk = ~clk;
  ripple_count_sampler u0 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .clr(clr), .match_val(match_val),
    .cnt_out(cnt_out), .valid(valid), .upd(upd), .match(match), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );
  ripple_count_sampler #(.WIDTH(4), .MODE_DOWN(0), .STABLE(1), .WRAP_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt1), .en(1'b1), .clr(1'b0), .match_val(4'd0),
    .cnt_out(cnt_out1), .valid(valid1), .upd(upd1), .match(match1), .wrap(wrap1), .wrap_cnt(wrap_cnt1)
  );
  typedef struct {
    int cnt, en, mv, hold, chk, e_cnt, e_upd, e_match, e_wrap, e_wcnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int cnt, int e, int mv, int hold, int c, int e_cnt,
                              int e_upd, int e_match, int e_wrap, int e_wcnt);
    vec_t r;
    r = '{cnt, e, mv, hold, c, e_cnt, e_upd, e_match, e_wrap, e_wcnt};
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n_upd   += int'(upd);
    n_match += int'(match);
    n_wrap  += int'(wrap);
    n_upd1  += int'(upd1);
    n_wrap1 += int'(wrap1);
  endtask
  task automatic clear_counts();
    n_upd = 0; n_match = 0; n_wrap = 0; n_upd1 = 0; n_wrap1 = 0;
  endtask
  initial begin
    for (int v = 14; v >= 0; v--) tbl.push_back(mk(v, 1, 0, 8, 1, v, 1, int'(v == 0), 0, 0));
    tbl.push_back(mk(15, 1, 0, 8, 1, 15, 1, 0, 1, 1));
    tbl.push_back(mk(8, 1, 0, 8, 1, 8, 1, 0, 0, 1));
    tbl.push_back(mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 1, 0, 8, 1, 7, 1, 0, 0, 1));
    tbl.push_back(mk(6, 1, 5, 8, 1, 6, 1, 0, 0, 1));
    tbl.push_back(mk(4, 1, 5, 8, 1, 4, 1, 0, 0, 1));
    tbl.push_back(mk(4, 1, 4, 4, 1, 4, 0, 0, 0, 1));
    tbl.push_back(mk(9, 0, 4, 8, 1, 4, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 4, 8, 1, 4, 0, 0, 0, 1));
    tbl.push_back(mk(3, 1, 4, 1, 1, 3, 1, 0, 0, 1));
    cnt_in = 4'hF; en = 1'b0; clr = 1'b0; match_val = 4'd0; cnt1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", int'(cnt_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_upd", int'(upd), 0);
    chk("rst_wcnt", int'(wrap_cnt), 0);
    rst_n = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();
    tick();
    chk("acq_e4_upd", int'(upd), 0);
    chk("acq_e4_valid", int'(valid), 0);
    tick();
    chk("acq_e5_cnt", int'(cnt_out), 15);
    chk("acq_e5_valid", int'(valid), 1);
    chk("acq_e5_upd", int'(upd), 1);
    chk("acq_e5_wrap", int'(wrap), 0);
    chk("acq_e5_wcnt", int'(wrap_cnt), 0);
    clear_counts();
    foreach (tbl[i]) begin
      cnt_in = 4'(tbl[i].cnt);
      en = tbl[i].en != 0;
      match_val = 4'(tbl[i].mv);
      repeat (tbl[i].hold) tick();
      if (tbl[i].chk != 0) begin
        chk($sformatf("v%0d_cnt", i), int'(cnt_out), tbl[i].e_cnt);
        chk($sformatf("v%0d_upd", i), n_upd, tbl[i].e_upd);
        chk($sformatf("v%0d_match", i), n_match, tbl[i].e_match);
        chk($sformatf("v%0d_wrap", i), n_wrap, tbl[i].e_wrap);
        chk($sformatf("v%0d_wcnt", i), int'(wrap_cnt), tbl[i].e_wcnt);
        clear_counts();
      end
    end
    cnt_in = 4'd8;
    repeat (4) tick();
    chk("clr_pre_upd", n_upd, 0);
    clr = 1'b1;
    tick();
    chk("clr_upd", int'(upd), 0);
    chk("clr_valid", int'(valid), 0);
    chk("clr_wcnt", int'(wrap_cnt), 0);
    chk("clr_cnt_hold", int'(cnt_out), 3);
    clr = 1'b0;
    tick();
    chk("post_clr_upd", int'(upd), 1);
    chk("post_clr_valid", int'(valid), 1);
    chk("post_clr_wrap", int'(wrap), 0);
    chk("post_clr_cnt", int'(cnt_out), 8);
    chk("post_clr_wcnt", int'(wrap_cnt), 0);
    clear_counts();
    for (int k = 0; k < 300; k++) begin
      cnt_in = 4'd0;
      repeat (6) tick();
      cnt_in = 4'hF;
      repeat (6) tick();
    end
    chk("sat_wraps", n_wrap, 300);
    chk("sat_upds", n_upd, 600);
    chk("sat_wcnt", int'(wrap_cnt), 255);
    cnt_in = 4'd5;
    en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", int'(cnt_out), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_upd", int'(upd), 0);
    chk("mid_rst_match", int'(match), 0);
    chk("mid_rst_wrap", int'(wrap), 0);
    chk("mid_rst_wcnt", int'(wrap_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();
    tick();
    chk("reacq_e4_upd", int'(upd), 0);
    tick();
    chk("reacq_cnt", int'(cnt_out), 5);
    chk("reacq_upd", int'(upd), 1);
    chk("reacq_wrap", int'(wrap), 0);
    chk("reacq_wcnt", int'(wrap_cnt), 0);
    clear_counts();
    for (int v = 1; v < 16; v++) begin
      cnt1 = 4'(v);
      repeat (6) tick();
    end
    cnt1 = 4'd0;
    repeat (6) tick();
    chk("up_upds", n_upd1, 16);
    chk("up_wraps", n_wrap1, 1);
    chk("up_wcnt", int'(wrap_cnt1), 1);
    chk("up_cnt", int'(cnt_out1), 0);
    clear_counts();
    cnt1 = 4'd5;
    tick();
    cnt1 = 4'd3;
    repeat (6) tick();
    chk("s1_glitch_upds", n_upd1, 1);
    chk("s1_glitch_cnt", int'(cnt_out1), 3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
